// File: rtl/replay_pipe_gen_if.sv
// ---------------------------------------------------------------------------
// replay_pipe_gen_if
//   Bundles the data, handshake and status signals of replay_pipe_gen.
//   master : producer / consumer side (drives in, in_vld, replay_w, stall_req)
//   slave  : the replay pipeline itself
// Signals:
//   in, in_vld, in_accept   write side of the replay FIFO
//   out_r, out_vld_r        last pipe stage
//   replay_w                replay request (registered inside the pipe)
//   stall_req               per-stage stall request, top bit ignored
//   occupancy_r             entries written and not yet committed
//   replay_cnt_r            saturating count of replay cycles
// ---------------------------------------------------------------------------
interface replay_pipe_gen_if #(
  parameter int N  = 10,
  parameter int W  = 32,
  parameter int AW = 3,
  parameter int CW = 16
);
  logic [W-1:0]  in;
  logic          in_vld;
  logic          in_accept;
  logic [W-1:0]  out_r;
  logic          out_vld_r;
  logic          replay_w;
  logic [N-1:0]  stall_req;
  logic [AW:0]   occupancy_r;
  logic [CW-1:0] replay_cnt_r;

  modport master (
    output in, in_vld, replay_w, stall_req,
    input  in_accept, out_r, out_vld_r, occupancy_r, replay_cnt_r
  );

  modport slave (
    input  in, in_vld, replay_w, stall_req,
    output in_accept, out_r, out_vld_r, occupancy_r, replay_cnt_r
  );
endinterface

// File: rtl/replay_pipe_gen.sv
// ---------------------------------------------------------------------------
// replay_pipe_gen
//   Input words are buffered in a 2^AW-entry replay FIFO, issued speculatively
//   into an N-stage stallable pipe and retired (committed) at COMMIT_STG.
//   A registered replay request kills stages 0..COMMIT_STG and rewinds the
//   speculative read pointer to the oldest uncommitted entry.
// Ports:
//   clk  clock
//   rst  synchronous reset, active-high
//   bus  replay_pipe_gen_if.slave (write side, output stage, replay, stall,
//        occupancy and replay-count status)
// ---------------------------------------------------------------------------
module replay_pipe_gen #(
  parameter int N          = 10,
  parameter int W          = 32,
  parameter int AW         = 3,
  parameter int COMMIT_STG = 8,
  parameter int CW         = 16
) (
  input  logic              clk,
  input  logic              rst,
  replay_pipe_gen_if.slave  bus
);

  localparam int DEPTH = 1 << AW;
  typedef logic [AW:0] ptr_t;   // wrap bit + index

  logic [W-1:0] fifo_mem [DEPTH];

  ptr_t wr_r, rd_arch_r, rd_spec_r;
  ptr_t wr_next, rd_arch_next, rd_spec_next;
  logic empty_r, full_r, replay_r;
  logic [AW:0]   occupancy_r;
  logic [CW-1:0] replay_cnt_r;

  // Pipe stages 1..N-1; stage 0 is the issue point and has no storage.
  logic [N-1:1] vld_r, vld_next, ld;
  logic [W-1:0] data_r [1:N-1];

  logic [N-2:0] v;      // stage-valid as seen by the stall chain (v[0]=1)
  logic [N-1:0] stall;
  logic [N-1:0] kill;
  logic [N-2:0] adv;
  logic         wr_en, commit;
  logic         unused_stall_top;

  assign unused_stall_top = bus.stall_req[N-1];

  assign wr_en         = bus.in_vld & ~full_r;
  assign bus.in_accept = ~full_r;

  // FIFO storage: contents are not reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_en) fifo_mem[wr_r[AW-1:0]] <= bus.in;
  end

  assign v = {vld_r[N-2:1], 1'b1};

  // Stalls ripple upstream only through valid stages, so bubbles absorb them.
  always_comb begin
    stall = '0;
    for (int i = N - 2; i >= 0; i--) begin
      stall[i] = v[i] & (bus.stall_req[i] | stall[i+1]);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_kill
      if (gi <= COMMIT_STG) begin : g_spec
        assign kill[gi] = replay_r;
      end else begin : g_safe
        assign kill[gi] = 1'b0;
      end
    end

    assign adv[0] = ~empty_r & ~stall[0] & ~kill[0];
    for (gi = 1; gi < N - 1; gi++) begin : g_adv
      assign adv[gi] = v[gi] & ~stall[gi] & ~kill[gi];
    end

    for (gi = 1; gi < N; gi++) begin : g_stage
      assign ld[gi]       = ~kill[gi] & ~stall[gi] & adv[gi-1];
      assign vld_next[gi] = kill[gi]  ? 1'b0 :
                            stall[gi] ? vld_r[gi] : adv[gi-1];
    end
  endgenerate

  // kill[COMMIT_STG] already masks adv during replay; kept explicit for clarity.
  assign commit = ~replay_r & adv[COMMIT_STG];

  always_comb begin
    wr_next      = wr_r + ptr_t'(wr_en);
    rd_arch_next = rd_arch_r + ptr_t'(commit);
    rd_spec_next = rd_spec_r;
    if (replay_r)    rd_spec_next = rd_arch_r;   // pre-commit value
    else if (adv[0]) rd_spec_next = rd_spec_r + ptr_t'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_r         <= '0;
      rd_arch_r    <= '0;
      rd_spec_r    <= '0;
      empty_r      <= 1'b1;
      full_r       <= 1'b0;
      replay_r     <= 1'b0;
      occupancy_r  <= '0;
      replay_cnt_r <= '0;
      vld_r        <= '0;
    end else begin
      wr_r         <= wr_next;
      rd_arch_r    <= rd_arch_next;
      rd_spec_r    <= rd_spec_next;
      // Flags come from next-state pointers so they match the pointers they
      // accompany; full is judged against the committed pointer so no
      // uncommitted entry can be overwritten.
      empty_r      <= (rd_spec_next == wr_next);
      full_r       <= (rd_arch_next[AW] != wr_next[AW]) &&
                      (rd_arch_next[AW-1:0] == wr_next[AW-1:0]);
      occupancy_r  <= wr_next - rd_arch_next;
      replay_r     <= bus.replay_w;
      if (replay_r && (replay_cnt_r != '1)) replay_cnt_r <= replay_cnt_r + CW'(1);
      vld_r        <= vld_next;
    end
  end

  // Data path carries no reset; stage 1 is the registered FIFO read.
  always_ff @(posedge clk) begin
    if (ld[1]) data_r[1] <= fifo_mem[rd_spec_r[AW-1:0]];
    for (int i = 2; i < N; i++) begin
      if (ld[i]) data_r[i] <= data_r[i-1];
    end
  end

  assign bus.out_r        = data_r[N-1];
  assign bus.out_vld_r    = vld_r[N-1];
  assign bus.occupancy_r  = occupancy_r;
  assign bus.replay_cnt_r = replay_cnt_r;

endmodule

// File: tb/tb_replay_pipe_gen.sv
// ---------------------------------------------------------------------------
// tb_replay_pipe_gen
//   Directed bench for replay_pipe_gen (N=10, W=32, AW=3, COMMIT_STG=8).
//   Each scenario task drives its own stimulus and compares against
//   hand-computed values. A negedge monitor records every output word with
//   the cycle it appeared in; cyc after the k-th edge of a scenario
//   (edges numbered E0, E1, ...) equals c0+k+1.
// ---------------------------------------------------------------------------
module tb_replay_pipe_gen;
  localparam int N  = 10;
  localparam int W  = 32;
  localparam int AW = 3;
  localparam int CS = 8;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic [W-1:0] cap[$];
  int           cap_cyc[$];

  replay_pipe_gen_if #(.N(N), .W(W), .AW(AW), .CW(CW)) bus_if ();

  replay_pipe_gen #(.N(N), .W(W), .AW(AW), .COMMIT_STG(CS), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && bus_if.out_vld_r === 1'b1) begin
      cap.push_back(bus_if.out_r);
      cap_cyc.push_back(cyc);
      $display("out data=%0d cyc=%0d occ=%0d", bus_if.out_r, cyc, bus_if.occupancy_r);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus_if.in        = '0;
    bus_if.in_vld    = 1'b0;
    bus_if.replay_w  = 1'b0;
    bus_if.stall_req = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cap.delete();
    cap_cyc.delete();
  endtask

  // Waits for n outputs (bounded), then lingers to expose any extras.
  task automatic wait_out(input int n, input int budget);
    for (int i = 0; i < budget && cap.size() < n; i++) tick();
    repeat (12) tick();
  endtask

  function automatic logic [W-1:0] cap_at(input int i);
    if (i < cap.size()) return cap[i];
    return 'x;
  endfunction

  function automatic int cyc_at(input int i);
    if (i < cap_cyc.size()) return cap_cyc[i];
    return -1;
  endfunction

  task automatic test_reset();
    bus_if.in        = 32'd99;
    bus_if.in_vld    = 1'b1;
    bus_if.replay_w  = 1'b1;
    bus_if.stall_req = '0;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (bus_if.out_vld_r !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_vld: got %b expected 0", bus_if.out_vld_r);
    end
    checks++;
    if (bus_if.in_accept !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_accept: got %b expected 1", bus_if.in_accept);
    end
    checks++;
    if (bus_if.occupancy_r !== 4'd0) begin
      failures++;
      $display("FAIL reset_occupancy: got %0d expected 0", bus_if.occupancy_r);
    end
    checks++;
    if (bus_if.replay_cnt_r !== 16'd0) begin
      failures++;
      $display("FAIL reset_replay_cnt: got %0d expected 0", bus_if.replay_cnt_r);
    end
    bus_if.in_vld   = 1'b0;
    bus_if.replay_w = 1'b0;
    rst = 1'b0;
  endtask

  // T1: 20 words streamed, top stall bit held high (must be ignored).
  task automatic test_stream();
    int c0, sent, guard;
    do_reset();
    bus_if.stall_req = N'(1) << (N - 1);
    c0 = cyc;
    sent = 0;
    guard = 0;
    while (sent < 20 && guard < 200) begin
      bus_if.in     = W'(sent);
      bus_if.in_vld = 1'b1;
      if (bus_if.in_accept === 1'b1) begin
        tick();
        sent++;
      end else begin
        tick();
      end
      guard++;
    end
    bus_if.in_vld = 1'b0;
    wait_out(20, 300);
    checks++;
    if (cap.size() !== 20) begin
      failures++;
      $display("FAIL stream_count: got %0d expected 20", cap.size());
    end
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (cap_at(i) !== W'(i)) begin
        failures++;
        $display("FAIL stream_data[%0d]: got %0d expected %0d", i, cap_at(i), i);
      end
    end
    // Counting the write cycle as cycle 1: write, flag/issue, then N-1 stages.
    checks++;
    if (cyc_at(0) - c0 + 1 !== 2 + (N - 1)) begin
      failures++;
      $display("FAIL stream_latency: got %0d expected %0d", cyc_at(0) - c0 + 1, 2 + (N - 1));
    end
    checks++;
    if (bus_if.occupancy_r !== 4'd0) begin
      failures++;
      $display("FAIL stream_occupancy: got %0d expected 0", bus_if.occupancy_r);
    end
    bus_if.stall_req = '0;
  endtask

  // T2: stage 1 held by stall_req[1]; FIFO fills at 8 entries.
  task automatic test_full();
    int sent;
    do_reset();
    bus_if.stall_req = N'(2);
    sent = 0;
    for (int i = 0; i < 12; i++) begin
      bus_if.in     = W'(100 + sent);
      bus_if.in_vld = (sent < 9);
      if (bus_if.in_vld && bus_if.in_accept === 1'b1) sent++;
      tick();
    end
    checks++;
    if (sent !== 8) begin
      failures++;
      $display("FAIL full_accepted: got %0d expected 8", sent);
    end
    checks++;
    if (bus_if.in_accept !== 1'b0) begin
      failures++;
      $display("FAIL full_in_accept: got %b expected 0", bus_if.in_accept);
    end
    checks++;
    if (bus_if.occupancy_r !== 4'd8) begin
      failures++;
      $display("FAIL full_occupancy: got %0d expected 8", bus_if.occupancy_r);
    end
    checks++;
    if (cap.size() !== 0) begin
      failures++;
      $display("FAIL full_no_output: got %0d expected 0", cap.size());
    end
    bus_if.stall_req = '0;
    for (int i = 0; i < 60 && sent < 9; i++) begin
      bus_if.in     = W'(100 + sent);
      bus_if.in_vld = 1'b1;
      if (bus_if.in_accept === 1'b1) sent++;
      tick();
    end
    bus_if.in_vld = 1'b0;
    checks++;
    if (sent !== 9) begin
      failures++;
      $display("FAIL full_release_accept: got %0d expected 9", sent);
    end
    wait_out(9, 200);
    checks++;
    if (cap.size() !== 9) begin
      failures++;
      $display("FAIL full_count: got %0d expected 9", cap.size());
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (cap_at(i) !== W'(100 + i)) begin
        failures++;
        $display("FAIL full_data[%0d]: got %0d expected %0d", i, cap_at(i), 100 + i);
      end
    end
  endtask

  // T3: replay_w sampled at E13 while word 5 sits in stage 8 and word 4 in
  // stage 9. Word 4 still leaves after E13; word 5 re-issues at E15 and
  // leaves after E23.
  task automatic test_replay();
    int c0;
    do_reset();
    c0 = cyc;
    for (int k = 0; k < 8; k++) begin
      bus_if.in     = W'(200 + k);
      bus_if.in_vld = 1'b1;
      tick();
    end
    bus_if.in_vld = 1'b0;
    repeat (5) tick();
    bus_if.replay_w = 1'b1;
    tick();
    bus_if.replay_w = 1'b0;
    wait_out(8, 200);
    checks++;
    if (cap.size() !== 8) begin
      failures++;
      $display("FAIL replay_count: got %0d expected 8", cap.size());
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cap_at(i) !== W'(200 + i)) begin
        failures++;
        $display("FAIL replay_data[%0d]: got %0d expected %0d", i, cap_at(i), 200 + i);
      end
    end
    checks++;
    if (cyc_at(4) !== c0 + 14) begin
      failures++;
      $display("FAIL replay_w4_cycle: got %0d expected %0d", cyc_at(4), c0 + 14);
    end
    checks++;
    if (cyc_at(5) !== c0 + 24) begin
      failures++;
      $display("FAIL replay_w5_cycle: got %0d expected %0d", cyc_at(5), c0 + 24);
    end
    checks++;
    if (bus_if.replay_cnt_r !== 16'd1) begin
      failures++;
      $display("FAIL replay_cnt: got %0d expected 1", bus_if.replay_cnt_r);
    end
    checks++;
    if (bus_if.occupancy_r !== 4'd0) begin
      failures++;
      $display("FAIL replay_occupancy: got %0d expected 0", bus_if.occupancy_r);
    end
  endtask

  // T4a: stall_req[4] raised while stage 4 is empty must not delay anything.
  task automatic test_stall_bubble();
    int c0;
    do_reset();
    c0 = cyc;
    bus_if.in     = W'(500);
    bus_if.in_vld = 1'b1;
    tick();
    bus_if.in_vld    = 1'b0;
    bus_if.stall_req = N'(1) << 4;
    repeat (4) tick();
    bus_if.stall_req = '0;
    wait_out(1, 100);
    checks++;
    if (cap_at(0) !== W'(500)) begin
      failures++;
      $display("FAIL bubble_data: got %0d expected 500", cap_at(0));
    end
    checks++;
    if (cyc_at(0) !== c0 + 10) begin
      failures++;
      $display("FAIL bubble_cycle: got %0d expected %0d", cyc_at(0), c0 + 10);
    end
  endtask

  // T4b: stall_req[4] sampled E7..E16 with word 2 in stage 4; words 0,1
  // downstream drain, word 2 resumes at E17 and leaves after E21.
  task automatic test_stall_drain();
    int c0;
    do_reset();
    c0 = cyc;
    for (int k = 0; k < 8; k++) begin
      bus_if.in     = W'(400 + k);
      bus_if.in_vld = 1'b1;
      if (k == 7) bus_if.stall_req = N'(1) << 4;
      tick();
    end
    bus_if.in_vld = 1'b0;
    repeat (9) tick();
    bus_if.stall_req = '0;
    wait_out(8, 200);
    checks++;
    if (cyc_at(1) !== c0 + 11) begin
      failures++;
      $display("FAIL drain_w1_cycle: got %0d expected %0d", cyc_at(1), c0 + 11);
    end
    checks++;
    if (cyc_at(2) !== c0 + 22) begin
      failures++;
      $display("FAIL drain_w2_cycle: got %0d expected %0d", cyc_at(2), c0 + 22);
    end
    checks++;
    if (cap.size() !== 8) begin
      failures++;
      $display("FAIL drain_count: got %0d expected 8", cap.size());
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cap_at(i) !== W'(400 + i)) begin
        failures++;
        $display("FAIL drain_data[%0d]: got %0d expected %0d", i, cap_at(i), 400 + i);
      end
    end
  endtask

  // T5: write of the 8th word coincides with replay_w at occupancy 7.
  task automatic test_corner();
    do_reset();
    bus_if.stall_req = N'(2);
    for (int k = 0; k < 7; k++) begin
      bus_if.in     = W'(600 + k);
      bus_if.in_vld = 1'b1;
      tick();
    end
    bus_if.in       = W'(607);
    bus_if.in_vld   = 1'b1;
    bus_if.replay_w = 1'b1;
    tick();
    bus_if.in_vld    = 1'b0;
    bus_if.replay_w  = 1'b0;
    bus_if.stall_req = '0;
    checks++;
    if (bus_if.occupancy_r !== 4'd8) begin
      failures++;
      $display("FAIL corner_occupancy: got %0d expected 8", bus_if.occupancy_r);
    end
    checks++;
    if (bus_if.in_accept !== 1'b0) begin
      failures++;
      $display("FAIL corner_in_accept: got %b expected 0", bus_if.in_accept);
    end
    wait_out(8, 200);
    checks++;
    if (cap.size() !== 8) begin
      failures++;
      $display("FAIL corner_count: got %0d expected 8", cap.size());
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cap_at(i) !== W'(600 + i)) begin
        failures++;
        $display("FAIL corner_data[%0d]: got %0d expected %0d", i, cap_at(i), 600 + i);
      end
    end
    checks++;
    if (bus_if.replay_cnt_r !== 16'd1) begin
      failures++;
      $display("FAIL corner_replay_cnt: got %0d expected 1", bus_if.replay_cnt_r);
    end
    checks++;
    if (bus_if.occupancy_r !== 4'd0) begin
      failures++;
      $display("FAIL corner_final_occupancy: got %0d expected 0", bus_if.occupancy_r);
    end
  endtask

  // T6: reset with 4 words in flight; only the next write may emerge.
  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      bus_if.in     = W'(700 + k);
      bus_if.in_vld = 1'b1;
      tick();
    end
    bus_if.in_vld = 1'b0;
    checks++;
    if (bus_if.occupancy_r !== 4'd4) begin
      failures++;
      $display("FAIL midrst_pre_occupancy: got %0d expected 4", bus_if.occupancy_r);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus_if.occupancy_r !== 4'd0) begin
      failures++;
      $display("FAIL midrst_occupancy: got %0d expected 0", bus_if.occupancy_r);
    end
    checks++;
    if (bus_if.out_vld_r !== 1'b0) begin
      failures++;
      $display("FAIL midrst_out_vld: got %b expected 0", bus_if.out_vld_r);
    end
    checks++;
    if (bus_if.in_accept !== 1'b1) begin
      failures++;
      $display("FAIL midrst_in_accept: got %b expected 1", bus_if.in_accept);
    end
    cap.delete();
    cap_cyc.delete();
    bus_if.in     = W'(710);
    bus_if.in_vld = 1'b1;
    tick();
    bus_if.in_vld = 1'b0;
    wait_out(1, 100);
    checks++;
    if (cap.size() !== 1) begin
      failures++;
      $display("FAIL midrst_count: got %0d expected 1", cap.size());
    end
    checks++;
    if (cap_at(0) !== W'(710)) begin
      failures++;
      $display("FAIL midrst_first: got %0d expected 710", cap_at(0));
    end
  endtask

  initial begin
    bus_if.in        = '0;
    bus_if.in_vld    = 1'b0;
    bus_if.replay_w  = 1'b0;
    bus_if.stall_req = '0;
    test_reset();
    test_stream();
    test_full();
    test_replay();
    test_stall_bubble();
    test_stall_drain();
    test_corner();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
